// File: rtl/argmax_arbiter.sv
// Round-robin sequencer that shares one argmax (max-finder) unit between classifier lanes.
// It grants a lane, hands its score vector to the max-finder and returns the class index to that lane.
module argmax_arbiter #(
  parameter int numReq        = 4,
  parameter int numInput      = 10,
  parameter int inputWidth    = 16,
  parameter int timeoutCycles = 32,
  localparam int IdW  = (numReq > 1) ? $clog2(numReq) : 1,
  localparam int VecW = numInput * inputWidth
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [numReq-1:0]              i_req_valid,
  input  logic [numReq*VecW-1:0]         i_req_data,
  output logic [numReq-1:0]              o_req_ready,
  output logic [VecW-1:0]                o_mf_data,
  output logic                           o_mf_valid,
  input  logic [31:0]                    i_mf_data,
  input  logic                           i_mf_valid,
  output logic [numReq-1:0]              o_resp_valid,
  output logic [31:0]                    o_resp_class,
  output logic [IdW-1:0]                 o_resp_id,
  output logic                           o_busy,
  output logic                           o_timeout_err
);

  localparam int CntW = $clog2(timeoutCycles + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [IdW-1:0]    resp_id_q, resp_id_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [VecW-1:0]   mf_data_q, mf_data_d;
  logic [31:0]       resp_class_q, resp_class_d;
  logic              timeout_err_q, timeout_err_d;

  logic [2*numReq-1:0] req_dbl;
  logic                gnt_found;
  logic [IdW-1:0]      gnt_off;
  logic [IdW:0]        gnt_sum;
  logic [IdW-1:0]      gnt_idx;
  logic [VecW-1:0]     gnt_vec;
  logic [IdW:0]        ptr_sum;

  // Scan from the pointer upward with wrap; the doubled vector makes the wrap a plain offset.
  always_comb begin
    req_dbl   = {i_req_valid, i_req_valid};
    gnt_found = 1'b0;
    gnt_off   = '0;
    for (int i = numReq - 1; i >= 0; i--) begin
      if (req_dbl[{1'b0, ptr_q} + (IdW+1)'(i)]) begin
        gnt_found = 1'b1;
        gnt_off   = IdW'(i);
      end
    end
    gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
    if (gnt_sum >= (IdW+1)'(numReq)) begin
      gnt_sum = gnt_sum - (IdW+1)'(numReq);
    end
    gnt_idx = gnt_sum[IdW-1:0];
    gnt_vec = '0;
    for (int i = 0; i < numReq; i++) begin
      if (gnt_idx == IdW'(i)) begin
        gnt_vec = i_req_data[i*VecW +: VecW];
      end
    end
    ptr_sum = {1'b0, resp_id_q} + (IdW+1)'(1);
    if (ptr_sum >= (IdW+1)'(numReq)) begin
      ptr_sum = '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    mf_data_d     = mf_data_q;
    resp_id_d     = resp_id_q;
    resp_class_d  = resp_class_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          mf_data_d = gnt_vec;
          resp_id_d = gnt_idx;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CntW'(1);
        // A real result beats a timeout landing in the same cycle.
        if (i_mf_valid) begin
          resp_class_d = i_mf_data;
          state_d      = S_RESP;
        end else if (cnt_q == CntW'(timeoutCycles - 1)) begin
          resp_class_d  = 32'hFFFF_FFFF;
          timeout_err_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = ptr_sum[IdW-1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      mf_data_q     <= '0;
      resp_id_q     <= '0;
      resp_class_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      mf_data_q     <= mf_data_d;
      resp_id_q     <= resp_id_d;
      resp_class_q  <= resp_class_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Accept pulse is suppressed while reset is asserted, since the edge will not capture.
  always_comb begin
    o_req_ready = '0;
    if (state_q == S_IDLE && gnt_found && !i_rst) begin
      o_req_ready[gnt_idx] = 1'b1;
    end
    o_resp_valid = '0;
    if (state_q == S_RESP) begin
      o_resp_valid[resp_id_q] = 1'b1;
    end
  end

  assign o_mf_valid    = (state_q == S_ISSUE);
  assign o_mf_data     = mf_data_q;
  assign o_resp_class  = resp_class_q;
  assign o_resp_id     = resp_id_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_argmax_arbiter.sv
// Bench for argmax_arbiter: lane/max-finder models driven per cycle, scoreboard queues of
// expected grants and responses compared as the DUT produces them.
module tb_argmax_arbiter;

  localparam int NR  = 4;
  localparam int NI  = 10;
  localparam int IW  = 16;
  localparam int TO  = 32;
  localparam int VW  = NI * IW;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [NR-1:0]     i_req_valid;
  logic [NR*VW-1:0]  i_req_data;
  logic [NR-1:0]     o_req_ready;
  logic [VW-1:0]     o_mf_data;
  logic              o_mf_valid;
  logic [31:0]       i_mf_data;
  logic              i_mf_valid;
  logic [NR-1:0]     o_resp_valid;
  logic [31:0]       o_resp_class;
  logic [IDW-1:0]    o_resp_id;
  logic              o_busy;
  logic              o_timeout_err;

  always #5 clk = ~clk;

  argmax_arbiter #(
    .numReq(NR), .numInput(NI), .inputWidth(IW), .timeoutCycles(TO)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .o_mf_data(o_mf_data), .o_mf_valid(o_mf_valid),
    .i_mf_data(i_mf_data), .i_mf_valid(i_mf_valid),
    .o_resp_valid(o_resp_valid), .o_resp_class(o_resp_class), .o_resp_id(o_resp_id),
    .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  int           req_cnt [NR];
  logic [VW-1:0] lane_data [NR];
  logic [NR-1:0] pulse_mask;
  logic          rst_next;
  logic          force_mf;
  int            mf_lat;
  int            mf_cd;
  logic [VW-1:0] mf_snap;
  int            last_rdy_cyc;
  int            last_mfv_cyc;
  bit            mfv_seen;

  int          grant_q [$];
  int          rid_q [$];
  logic [31:0] rcls_q [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int argmax_vec(input logic [VW-1:0] v);
    int best = 0;
    for (int i = 1; i < NI; i++) begin
      if (v[i*IW +: IW] > v[best*IW +: IW]) best = i;
    end
    return best;
  endfunction

  function automatic int pending();
    int p = grant_q.size() + rid_q.size() + (o_busy ? 1 : 0);
    for (int k = 0; k < NR; k++) p += req_cnt[k];
    return p;
  endfunction

  task automatic rand_lane(input int k, input int idx, input int top);
    for (int i = 0; i < NI; i++) lane_data[k][i*IW +: IW] = IW'($urandom_range(0, 999));
    lane_data[k][idx*IW +: IW] = IW'(top);
  endtask

  task automatic expect_txn(input int lane, input bit has_resp, input logic [31:0] cls);
    grant_q.push_back(lane);
    if (has_resp) begin
      rid_q.push_back(lane);
      rcls_q.push_back(cls);
    end
  endtask

  // One clock: drive after the rising edge, observe on the falling edge.
  task automatic step();
    int g;
    int exp_lat;
    int rid;
    logic [31:0] rcls;
    @(posedge clk);
    #1;
    cyc++;
    i_rst = rst_next;
    for (int k = 0; k < NR; k++) begin
      i_req_valid[k] = (req_cnt[k] > 0) || pulse_mask[k];
      i_req_data[k*VW +: VW] = lane_data[k];
    end
    pulse_mask = '0;
    i_mf_valid = 1'b0;
    if (mf_cd > 0) begin
      mf_cd--;
      if (mf_cd == 0) begin
        i_mf_valid = 1'b1;
        i_mf_data  = 32'(argmax_vec(mf_snap));
        mf_cd      = -1;
      end
    end
    if (force_mf) begin
      i_mf_valid = 1'b1;
      i_mf_data  = 32'd5;
      force_mf   = 1'b0;
    end
    @(negedge clk);
    if (o_req_ready != '0) begin
      last_rdy_cyc = cyc;
      if (grant_q.size() == 0) begin
        check("unexpected_ready", 64'(o_req_ready), 64'd0);
      end else begin
        g = grant_q.pop_front();
        check("ready_onehot", 64'(o_req_ready), 64'd1 << g);
      end
      for (int k = 0; k < NR; k++) begin
        if (o_req_ready[k] && req_cnt[k] > 0) req_cnt[k]--;
      end
    end
    if (o_mf_valid) begin
      check("issue_latency", 64'(cyc), 64'(last_rdy_cyc + 1));
      last_mfv_cyc = cyc;
      mfv_seen     = 1'b1;
      mf_snap      = o_mf_data;
      if (mf_lat > 0) mf_cd = mf_lat;
    end
    if (o_resp_valid != '0) begin
      if (rid_q.size() == 0) begin
        check("unexpected_resp", 64'(o_resp_valid), 64'd0);
      end else begin
        rid  = rid_q.pop_front();
        rcls = rcls_q.pop_front();
        exp_lat = (mf_lat == 0 || mf_lat > TO) ? TO + 1 : mf_lat + 1;
        check("resp_onehot", 64'(o_resp_valid), 64'd1 << rid);
        check("resp_id", 64'(o_resp_id), 64'(rid));
        check("resp_class", 64'(o_resp_class), 64'(rcls));
        check("resp_latency", 64'(cyc - last_mfv_cyc), 64'(exp_lat));
        check("mf_data_stable", 64'(o_mf_data == mf_snap), 64'd1);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain", 64'(pending()), 64'd0);
  endtask

  task automatic wait_issue(input int budget);
    int n = 0;
    mfv_seen = 1'b0;
    while (!mfv_seen && n < budget) begin
      step();
      n++;
    end
    check("issue_seen", 64'(mfv_seen), 64'd1);
  endtask

  task automatic check_reset_state();
    check("rst_ready", 64'(o_req_ready), 64'd0);
    check("rst_mf_valid", 64'(o_mf_valid), 64'd0);
    check("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    check("rst_resp_class", 64'(o_resp_class), 64'd0);
    check("rst_resp_id", 64'(o_resp_id), 64'd0);
    check("rst_mf_data_zero", 64'(o_mf_data == '0), 64'd1);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_timeout_err", 64'(o_timeout_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_req_valid = '0; i_req_data = '0; i_mf_valid = 1'b0; i_mf_data = '0;
    pulse_mask = '0; rst_next = 1'b1; force_mf = 1'b0;
    mf_lat = 0; mf_cd = -1; mf_snap = '0; last_rdy_cyc = 0; last_mfv_cyc = 0; mfv_seen = 1'b0;
    for (int k = 0; k < NR; k++) begin
      req_cnt[k] = 0;
      lane_data[k] = '0;
    end

    step(); step();
    check_reset_state();
    rst_next = 1'b0;
    step();

    // Single lane 2, scores {3,9,1,0...}: class 1.
    lane_data[2] = '0;
    lane_data[2][0*IW +: IW] = 16'd3;
    lane_data[2][1*IW +: IW] = 16'd9;
    lane_data[2][2*IW +: IW] = 16'd1;
    mf_lat = 11;
    expect_txn(2, 1'b1, 32'd1);
    req_cnt[2] = 1;
    drain(100);
    check("t1_class_hold", 64'(o_resp_class), 64'd1);
    check("t1_id_hold", 64'(o_resp_id), 64'd2);

    // All lanes requesting from reset: 0,1,2,3,0.
    rst_next = 1'b1; step(); rst_next = 1'b0; step();
    rand_lane(0, 3, 2000); rand_lane(1, 0, 2001); rand_lane(2, 9, 2002); rand_lane(3, 5, 2003);
    expect_txn(0, 1'b1, 32'd3);
    expect_txn(1, 1'b1, 32'd0);
    expect_txn(2, 1'b1, 32'd9);
    expect_txn(3, 1'b1, 32'd5);
    expect_txn(0, 1'b1, 32'd3);
    req_cnt[0] = 2; req_cnt[1] = 1; req_cnt[2] = 1; req_cnt[3] = 1;
    drain(300);

    // Hung max-finder: timeout, late result ignored, next request normal.
    mf_lat = 0;
    rand_lane(1, 4, 2500);
    expect_txn(1, 1'b1, 32'hFFFF_FFFF);
    req_cnt[1] = 1;
    drain(100);
    check("t3_err_set", 64'(o_timeout_err), 64'd1);
    check("t3_class_hold", 64'(o_resp_class), 64'hFFFF_FFFF);
    step(); step(); step();
    force_mf = 1'b1;
    step(); step(); step(); step();
    mf_lat = 11;
    rand_lane(2, 6, 2600);
    expect_txn(2, 1'b1, 32'd6);
    req_cnt[2] = 1;
    drain(100);
    check("t3_err_sticky", 64'(o_timeout_err), 64'd1);

    // Lane 1 arrives during lane 0's WAIT; lane 3 pulses once and must never be granted.
    rand_lane(0, 2, 2700); rand_lane(1, 8, 2701);
    expect_txn(0, 1'b1, 32'd2);
    expect_txn(1, 1'b1, 32'd8);
    req_cnt[0] = 1;
    wait_issue(20);
    step(); step();
    req_cnt[1] = 1;
    pulse_mask = 4'b1000;
    drain(200);

    // Reset in WAIT, then a stray result: no response, pointer back to 0.
    mf_lat = 0;
    rand_lane(2, 1, 2800);
    expect_txn(2, 1'b0, 32'd0);
    req_cnt[2] = 1;
    wait_issue(20);
    step(); step();
    rst_next = 1'b1; step();
    rst_next = 1'b0; step();
    check_reset_state();
    step();
    force_mf = 1'b1;
    step(); step(); step();
    check("t5_idle_after_stray", 64'(o_busy), 64'd0);
    mf_lat = 11;
    rand_lane(0, 5, 2900); rand_lane(3, 9, 2901);
    expect_txn(0, 1'b1, 32'd5);
    expect_txn(3, 1'b1, 32'd9);
    req_cnt[0] = 1; req_cnt[3] = 1;
    drain(200);

    // Result lands on the last WAIT cycle before timeout: result wins.
    mf_lat = TO;
    rand_lane(1, 7, 3000);
    expect_txn(1, 1'b1, 32'd7);
    req_cnt[1] = 1;
    drain(100);
    check("t6_err_clear", 64'(o_timeout_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
